// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART transmitter between
// NREQ byte-stream requesters, optionally prefixing each packet with HDR_BASE|id.
module uart_tx_arbiter #(
  parameter int         NREQ     = 4,
  parameter bit         HDR_EN   = 1'b1,
  parameter logic [7:0] HDR_BASE = 8'hA0,
  parameter int         TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ready,
  output logic [7:0]          tx_data,
  output logic                tx_wr,
  input  logic                tx_busy,
  output logic [NREQ-1:0]     grant,
  output logic                timeout
);

  localparam int             CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [3:0]     NREQ4   = 4'(NREQ);
  localparam logic [3:0]     LAST_ID = 4'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WSTART,
    S_WDONE
  } state_t;

  state_t            state_q;
  logic [NREQ-1:0]   grant_q;
  logic [3:0]        id_q;
  logic [3:0]        rr_ptr_q;
  logic [7:0]        tx_data_q;
  logic              tx_wr_q;
  logic              last_q;
  logic              timeout_q;
  logic [CW-1:0]     cnt_q;

  logic [NREQ-1:0]   rot;
  logic [3:0]        pick_off;
  logic [3:0]        pick_id;
  logic [3:0]        next_ptr;
  logic              g_valid;
  logic [7:0]        g_data;
  logic              g_last;

  // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit wins.
  always_comb begin
    rot      = NREQ'({req_valid, req_valid} >> rr_ptr_q);
    pick_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) pick_off = 4'(k);
    end
    pick_id = rr_ptr_q + pick_off;
    if (pick_id >= NREQ4) pick_id = pick_id - NREQ4;
  end

  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    g_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        g_valid = req_valid[i];
        g_data  = req_data[8*i +: 8];
        g_last  = req_last[i];
      end
    end
  end

  assign next_ptr  = (id_q == LAST_ID) ? 4'd0 : id_q + 4'd1;
  assign req_ready = (state_q == S_DATA && !tx_busy) ? grant_q : '0;
  assign grant     = grant_q;
  assign tx_data   = tx_data_q;
  assign tx_wr     = tx_wr_q;
  assign timeout   = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      rr_ptr_q  <= '0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      last_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            grant_q <= NREQ'(1) << pick_id;
            id_q    <= pick_id;
            state_q <= HDR_EN ? S_HDR : S_DATA;
          end
        end
        S_HDR: begin
          if (!tx_busy) begin
            tx_data_q <= HDR_BASE | {4'b0000, id_q};
            tx_wr_q   <= 1'b1;
            last_q    <= 1'b0;
            state_q   <= S_WSTART;
          end
        end
        S_DATA: begin
          if (g_valid) begin
            cnt_q <= '0;
            if (!tx_busy) begin
              tx_data_q <= g_data;
              tx_wr_q   <= 1'b1;
              last_q    <= g_last;
              state_q   <= S_WSTART;
            end
          end else if (TIMEOUT != 0) begin
            // A silent owner is evicted so it cannot stall the others forever.
            if (cnt_q == TO_LAST) begin
              cnt_q     <= '0;
              timeout_q <= 1'b1;
              grant_q   <= '0;
              rr_ptr_q  <= next_ptr;
              state_q   <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_WSTART: begin
          tx_wr_q <= 1'b0;
          state_q <= S_WDONE;
        end
        S_WDONE: begin
          if (!tx_busy) begin
            if (last_q) begin
              grant_q  <= '0;
              rr_ptr_q <= next_ptr;
              state_q  <= S_IDLE;
            end else begin
              state_q  <= S_DATA;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a header-enabled instance (TIMEOUT=16) and a
// payload-only instance, each with a queue-driven requester model and a UART busy model.
module tb_uart_tx_arbiter;

  localparam int FRAME = 5;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid [2];
  logic [31:0] req_data  [2];
  logic [3:0]  req_last  [2];
  logic [3:0]  req_ready [2];
  logic [7:0]  tx_data   [2];
  logic        tx_wr     [2];
  logic        tx_busy   [2];
  logic [3:0]  grant     [2];
  logic        timeout   [2];

  logic [8:0]  rq [8][$];
  logic [7:0]  txlog [2][$];
  int          txcyc [2][$];
  logic [7:0]  exp_q [$];
  int          busy_cnt [2];
  int          wr_busy [2];
  int          tocnt [2];
  int          tocyc [2];
  int          acc_cnt [8];
  int          cyc;
  int          checks;
  int          errors;

  uart_tx_arbiter #(.NREQ(4), .HDR_EN(1'b1), .HDR_BASE(8'hA0), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_data(req_data[0]), .req_last(req_last[0]),
    .req_ready(req_ready[0]), .tx_data(tx_data[0]), .tx_wr(tx_wr[0]),
    .tx_busy(tx_busy[0]), .grant(grant[0]), .timeout(timeout[0])
  );

  uart_tx_arbiter #(.NREQ(4), .HDR_EN(1'b0), .HDR_BASE(8'hA0), .TIMEOUT(0)) dut_nh (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_data(req_data[1]), .req_last(req_last[1]),
    .req_ready(req_ready[1]), .tx_data(tx_data[1]), .tx_wr(tx_wr[1]),
    .tx_busy(tx_busy[1]), .grant(grant[1]), .timeout(timeout[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive from the queues, snapshot just before the edge, then apply effects.
  task automatic cycle();
    logic [3:0] acc [2];
    logic       wr  [2];
    logic [7:0] wd  [2];
    logic       bsy [2];
    logic       to  [2];
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (rq[d*4+i].size() > 0) begin
          req_valid[d][i]       = 1'b1;
          req_data[d][8*i +: 8] = rq[d*4+i][0][7:0];
          req_last[d][i]        = rq[d*4+i][0][8];
        end else begin
          req_valid[d][i]       = 1'b0;
          req_data[d][8*i +: 8] = 8'hEE;
          req_last[d][i]        = 1'b1;
        end
      end
      tx_busy[d] = (busy_cnt[d] != 0);
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      acc[d] = req_valid[d] & req_ready[d];
      wr[d]  = tx_wr[d];
      wd[d]  = tx_data[d];
      bsy[d] = tx_busy[d];
      to[d]  = timeout[d];
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (acc[d][i]) begin
          void'(rq[d*4+i].pop_front());
          acc_cnt[d*4+i]++;
        end
      end
      if (wr[d]) begin
        txlog[d].push_back(wd[d]);
        txcyc[d].push_back(cyc);
        $display("[%0d] dut%0d uart byte %02h", cyc, d, wd[d]);
        if (bsy[d]) wr_busy[d]++;
        busy_cnt[d] = FRAME;
      end else if (busy_cnt[d] > 0) begin
        busy_cnt[d]--;
      end
      if (to[d]) begin
        tocnt[d]++;
        tocyc[d] = cyc;
        $display("[%0d] dut%0d timeout pulse", cyc, d);
      end
    end
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      txlog[d].delete();
      txcyc[d].delete();
      tocnt[d] = 0;
    end
    for (int i = 0; i < 8; i++) acc_cnt[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) rq[i].delete();
    busy_cnt[0] = 0;
    busy_cnt[1] = 0;
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    clear_logs();
  endtask

  task automatic run_until(input int d, input int n, input string tag);
    int k;
    k = 0;
    while (k < 400 && !(txlog[d].size() >= n && grant[d] == 4'd0 &&
           rq[d*4].size() == 0 && rq[d*4+1].size() == 0 &&
           rq[d*4+2].size() == 0 && rq[d*4+3].size() == 0)) begin
      cycle();
      k++;
    end
    check({tag, "_count"}, 32'(txlog[d].size()), 32'(n));
    check({tag, "_grant_idle"}, 32'(grant[d]), 32'd0);
  endtask

  task automatic check_log(input int d, input string tag);
    for (int k = 0; k < exp_q.size(); k++) begin
      check($sformatf("%s_byte%0d", tag, k),
            (k < txlog[d].size()) ? 32'(txlog[d][k]) : 32'hDEAD, 32'(exp_q[k]));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0;
      req_data[d]  = '0;
      req_last[d]  = '0;
      tx_busy[d]   = 1'b0;
      busy_cnt[d]  = 0;
      wr_busy[d]   = 0;
      tocyc[d]     = 0;
    end
    clear_logs();
    reset = 1'b1;
    #1;
    check("rst_grant", 32'(grant[0]), 32'd0);
    check("rst_tx_wr", 32'(tx_wr[0]), 32'd0);
    check("rst_tx_data", 32'(tx_data[0]), 32'd0);
    check("rst_timeout", 32'(timeout[0]), 32'd0);
    check("rst_req_ready", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    do_reset();

    // Single packet from req0, then rr_ptr must favour req1 over req0.
    rq[0].push_back(9'h055);
    rq[0].push_back(9'h1AA);
    run_until(0, 3, "t1");
    exp_q = '{8'hA0, 8'h55, 8'hAA};
    check_log(0, "t1");
    clear_logs();
    rq[0].push_back(9'h110);
    rq[1].push_back(9'h120);
    run_until(0, 4, "t1b");
    exp_q = '{8'hA1, 8'h20, 8'hA0, 8'h10};
    check_log(0, "t1b");

    // Two competing 2-byte packets must not interleave.
    do_reset();
    rq[1].push_back(9'h031);
    rq[1].push_back(9'h132);
    rq[2].push_back(9'h041);
    rq[2].push_back(9'h142);
    run_until(0, 6, "t2");
    exp_q = '{8'hA1, 8'h31, 8'h32, 8'hA2, 8'h41, 8'h42};
    check_log(0, "t2");

    // All four requesters continuously offering 1-byte packets: two full rounds.
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      rq[i].push_back(9'h100 | 9'(i * 16));
      rq[i].push_back(9'h101 | 9'(i * 16));
    end
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(8'hA0 | 8'(i));
        exp_q.push_back(8'(i * 16 + j));
      end
    end
    run_until(0, 16, "t3");
    check_log(0, "t3");
    for (int i = 0; i < 4; i++) check($sformatf("t3_accepts%0d", i), 32'(acc_cnt[i]), 32'd2);
    check("t3_no_timeout", 32'(tocnt[0]), 32'd0);

    // req0 stalls mid-packet: forced release after 16 idle DATA cycles, then req3.
    do_reset();
    rq[0].push_back(9'h011);
    rq[3].push_back(9'h133);
    run_until(0, 4, "t4");
    exp_q = '{8'hA0, 8'h11, 8'hA3, 8'h33};
    check_log(0, "t4");
    check("t4_timeout_pulses", 32'(tocnt[0]), 32'd1);
    check("t4_timeout_delay", (txcyc[0].size() > 1) ? 32'(tocyc[0] - txcyc[0][1]) : 32'hDEAD, 32'd23);

    // Asynchronous reset while waiting in WDONE with the UART busy.
    do_reset();
    rq[0].push_back(9'h077);
    rq[0].push_back(9'h178);
    for (int k = 0; k < 100 && txlog[0].size() < 2; k++) cycle();
    cycle();
    check("t5_pre_grant", 32'(grant[0]), 32'd1);
    check("t5_pre_tx_data", 32'(tx_data[0]), 32'h77);
    tx_busy[0] = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_grant", 32'(grant[0]), 32'd0);
    check("t5_async_tx_wr", 32'(tx_wr[0]), 32'd0);
    check("t5_async_tx_data", 32'(tx_data[0]), 32'd0);
    check("t5_async_req_ready", 32'(req_ready[0]), 32'd0);
    do_reset();
    rq[2].push_back(9'h199);
    run_until(0, 2, "t5");
    exp_q = '{8'hA2, 8'h99};
    check_log(0, "t5");

    // Payload-only instance.
    rq[7].push_back(9'h001);
    rq[7].push_back(9'h102);
    run_until(1, 2, "t6");
    exp_q = '{8'h01, 8'h02};
    check_log(1, "t6");

    check("wr_while_busy_dut", 32'(wr_busy[0]), 32'd0);
    check("wr_while_busy_nh", 32'(wr_busy[1]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
